seq_mult_sched: RTL and testbench

//  Sequential NxN unsigned multiplier scheduler built around one shared 2x2-bit multiplier core.
//  - Splits operands A and B into 2-bit digits.
//  - Issues one digit pair per cycle to the core.
//  - Shifts each 4-bit partial product by 2*(i+j) and accumulates it into a 2N-bit product.
//  - Sits between a requester (valid/ready) and the small combinational multiplier datapath.

---
 rtl/seq_mult_pkg.sv | 14 +
 rtl/mul2x2_core.sv | 28 ++
 rtl/seq_mult_sched.sv | 138 +++++++++++++
 tb/tb_seq_mult_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the digit-serial multiplier scheduler.
// States plus digit and partial-product widths.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DIG_W = 2;
    localparam int PP_W  = 4;

endpackage

// File: rtl/mul2x2_core.sv
// Gate-level combinational 2x2-bit unsigned multiplier.
// Result p = {a1,a0} * {b1,b0}.
module mul2x2_core
    import seq_mult_pkg::*;
(
    input  logic [DIG_W-1:0] i_a,
    input  logic [DIG_W-1:0] i_b,
    output logic [PP_W-1:0]  o_p
);

    logic w_a0b0;
    logic w_a1b0;
    logic w_a0b1;
    logic w_a1b1;
    logic w_c1;

    assign w_a0b0 = i_a[0] & i_b[0];
    assign w_a1b0 = i_a[1] & i_b[0];
    assign w_a0b1 = i_a[0] & i_b[1];
    assign w_a1b1 = i_a[1] & i_b[1];
    assign w_c1   = w_a1b0 & w_a0b1;

    assign o_p[0] = w_a0b0;
    assign o_p[1] = w_a1b0 ^ w_a0b1;
    assign o_p[2] = w_a1b1 ^ w_c1;
    assign o_p[3] = w_a1b1 & w_c1;

endmodule

// File: rtl/seq_mult_sched.sv
// Digit-serial NxN unsigned multiplier: one 2x2 digit pair per cycle
// through a single shared core, shifted and accumulated into 2N bits.
module seq_mult_sched
    import seq_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int D  = N / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [CW-1:0]    r_i;
    logic [CW-1:0]    r_j;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_product;

    logic             w_accept;
    logic             w_j_end;
    logic             w_i_end;
    logic             w_last;
    logic [DIG_W-1:0] w_a_dig;
    logic [DIG_W-1:0] w_b_dig;
    logic [PP_W-1:0]  w_pp;
    logic [CW:0]      w_isum;
    logic [CW+1:0]    w_shamt;
    logic [2*N-1:0]   w_term;
    logic [2*N-1:0]   w_acc_nxt;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_CALC) || (r_state == S_DONE);
    assign product   = r_product;

    assign w_accept = in_valid && in_ready;
    assign w_j_end  = (r_j == CW'(D - 1));
    assign w_i_end  = (r_i == CW'(D - 1));
    assign w_last   = w_i_end && w_j_end;

    assign w_a_dig = DIG_W'(r_a >> {r_i, 1'b0});
    assign w_b_dig = DIG_W'(r_b >> {r_j, 1'b0});

    mul2x2_core u_core (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_pp)
    );

    // Digit weight is 4^(i+j), i.e. a left shift of 2*(i+j).
    assign w_isum    = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt   = {w_isum, 1'b0};
    assign w_term    = {{(2*N-PP_W){1'b0}}, w_pp} << w_shamt;
    assign w_acc_nxt = r_acc + w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_a   <= a_in;
                r_b   <= b_in;
                r_i   <= '0;
                r_j   <= '0;
                r_acc <= '0;
            end
        end else if (r_state == S_CALC) begin
            if (abort) begin
                r_i <= '0;
                r_j <= '0;
            end else begin
                r_acc <= w_acc_nxt;
                if (w_last) begin
                    r_product <= w_acc_nxt;
                    r_i       <= '0;
                    r_j       <= '0;
                end else if (w_j_end) begin
                    r_j <= '0;
                    r_i <= r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_sched.sv
// Directed self-checking bench for seq_mult_sched (N=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_mult_sched;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int checks;
    int errors;

    seq_mult_sched #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one cycle; afterwards scramble the inputs.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic ab);
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        abort    = ab;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        a_in     = ~a;
        b_in     = ~b;
    endtask

    // Count falling edges until out_valid, bounded at 40.
    task automatic wait_done(output int cyc, output bit busy_low);
        cyc      = 0;
        busy_low = 1'b0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_low = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, product} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL reset: rdy/vld/busy/prod got %b%b%b %h want 100 0000",
                     in_ready, out_valid, busy, product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        bit bl;
        issue(8'hA5, 8'h3C, 1'b0);
        wait_done(cyc, bl);
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL latency: got %0d want 16", cyc);
        end
        checks++;
        if (product !== 16'h26AC) begin
            errors++;
            $display("FAIL a5x3c: got %h want 26ac", product);
        end
        release_out();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL post_done: got %b want 100",
                     {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_edges();
        int cyc;
        bit bl;
        issue(8'hFF, 8'hFF, 1'b0);
        wait_done(cyc, bl);
        checks++;
        if (product !== 16'hFE01 || cyc !== 16) begin
            errors++;
            $display("FAIL ffxff: got %h cyc %0d want fe01 cyc 16", product, cyc);
        end
        checks++;
        if (bl) begin
            errors++;
            $display("FAIL busy_ff: got busy low want high");
        end
        release_out();
        issue(8'h00, 8'h7B, 1'b0);
        wait_done(cyc, bl);
        checks++;
        if (product !== 16'h0000 || cyc !== 16) begin
            errors++;
            $display("FAIL 0x7b: got %h cyc %0d want 0000 cyc 16", product, cyc);
        end
        checks++;
        if (bl) begin
            errors++;
            $display("FAIL busy_zero: got busy low want high");
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int cyc;
        bit bl;
        bit bad;
        issue(8'h0D, 8'h0B, 1'b0);
        wait_done(cyc, bl);
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                product !== 16'h008F) bad = 1'b1;
            abort = (k >= 3);
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold: got vld %b rdy %b prod %h want 1 0 008f",
                     out_valid, in_ready, product);
        end
        checks++;
        if (out_valid !== 1'b1 || product !== 16'h008F) begin
            errors++;
            $display("FAIL abort_done: got vld %b prod %h want 1 008f",
                     out_valid, product);
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy %b vld %b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        bit bl;
        issue(8'h0F, 8'h0F, 1'b0);
        repeat (3) @(negedge clk);
        a_in     = 8'h11;
        b_in     = 8'h22;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_rdy: got %b want 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(cyc, bl);
        checks++;
        if (product !== 16'h00E1 || cyc !== 12) begin
            errors++;
            $display("FAIL ignore: got %h cyc %0d want 00e1 cyc 12", product, cyc);
        end
        release_out();
    endtask

    task automatic test_abort();
        int cyc;
        bit bl;
        bit seen;
        issue(8'h12, 8'h34, 1'b0);
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 16'h00E1) begin
            errors++;
            $display("FAIL abort: got %b %h want 100 00e1",
                     {in_ready, out_valid, busy}, product);
        end
        seen = 1'b0;
        repeat (20) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_vld: got out_valid 1 want 0");
        end
        issue(8'h03, 8'h05, 1'b1);
        wait_done(cyc, bl);
        checks++;
        if (product !== 16'h000F || cyc !== 16) begin
            errors++;
            $display("FAIL abort_accept: got %h cyc %0d want 000f cyc 16",
                     product, cyc);
        end
        release_out();
    endtask

    task automatic test_async_reset();
        int cyc;
        bit bl;
        issue(8'hA5, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, product} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL async_rst: got %b %h want 100 0000",
                     {in_ready, out_valid, busy}, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h80, 8'h02, 1'b0);
        wait_done(cyc, bl);
        checks++;
        if (product !== 16'h0100 || cyc !== 16) begin
            errors++;
            $display("FAIL post_rst: got %h cyc %0d want 0100 cyc 16", product, cyc);
        end
        release_out();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_edges();
        test_backpressure();
        test_busy_ignore();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
